// File: rtl/loctag_pkg.sv
// loctag_pkg: shared encodings, shift half-period table and default constants for the LocTag tag
package loctag_pkg;
    typedef enum logic [1:0] {MODE_1M = 2'b00, MODE_2M5 = 2'b01, MODE_5M = 2'b10, MODE_12M5 = 2'b11} mode_t;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLDOFF} state_t;
    localparam int          SAMPLE_DIV_D   = 100;
    localparam logic [11:0] THRESHOLD_D    = 12'd1000;
    localparam int          DETECT_N_D     = 3;
    localparam int          BURST_CYCLES_D = 50000;
    localparam logic [6:0]  FRAME_LEN      = 7'd66;
    localparam logic [4:0]  HALF [4]       = '{5'd25, 5'd10, 5'd5, 5'd2};
endpackage

// File: rtl/loctag_if.sv
// loctag_if: detector enable and serial ADC bus
interface loctag_if;
    logic lt5534_en;
    logic adc_cs;
    logic adc_clk;
    logic adc_so;
    modport master(output lt5534_en, adc_cs, adc_clk, input adc_so);
    modport slave(input lt5534_en, adc_cs, adc_clk, output adc_so);
endinterface

// File: rtl/loctag_adc_rx.sv
// loctag_adc_rx: periodic 16-clock serial ADC read producing a 12-bit sample and a 1-cycle valid
module loctag_adc_rx import loctag_pkg::*; #(
    parameter int SAMPLE_DIV = SAMPLE_DIV_D
) (
    input  logic            clk,
    input  logic            reset,
    loctag_if.master        adc,
    output logic [11:0]     sample,
    output logic            sample_valid
);
    localparam int DW = $clog2(SAMPLE_DIV);
    logic [DW-1:0] div;
    logic [6:0]    k;
    logic [6:0]    n;
    logic [11:0]   shreg;
    logic          busy;
    logic          tick;
    assign tick = div == DW'(SAMPLE_DIV - 1);
    assign n    = k + 7'd1;
    always_ff @(posedge clk) begin
        if (!reset) begin
            div           <= '0;
            k             <= '0;
            shreg         <= '0;
            busy          <= 1'b0;
            sample        <= '0;
            sample_valid  <= 1'b0;
            adc.lt5534_en <= 1'b0;
            adc.adc_cs    <= 1'b1;
            adc.adc_clk   <= 1'b1;
        end else begin
            adc.lt5534_en <= 1'b1;
            sample_valid  <= 1'b0;
            div           <= tick ? '0 : div + 1'b1;
            if (tick && !busy) begin
                busy        <= 1'b1;
                k           <= '0;
                adc.adc_cs  <= 1'b0;
                adc.adc_clk <= 1'b1;
            end else if (busy) begin
                k           <= n;
                // two setup cycles, then 16 periods low-low-high-high
                adc.adc_clk <= !(n[1] && n < FRAME_LEN);
                // the 4 leading zeros fall off the top of the 12-bit register
                if (n[1:0] == 2'b00 && n >= 7'd4 && n <= 7'd64)
                    shreg <= {shreg[10:0], adc.adc_so};
                if (n == FRAME_LEN) begin
                    busy         <= 1'b0;
                    adc.adc_cs   <= 1'b1;
                    sample       <= shreg;
                    sample_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/loctag_core.sv
// loctag_core: envelope/trigger detection, burst FSM and frequency-shift generator for the LocTag tag
module loctag_core import loctag_pkg::*; #(
    parameter int          SAMPLE_DIV   = SAMPLE_DIV_D,
    parameter logic [11:0] THRESHOLD    = THRESHOLD_D,
    parameter int          DETECT_N     = DETECT_N_D,
    parameter int          BURST_CYCLES = BURST_CYCLES_D
) (
    input  logic        clk,
    input  logic        reset,
    loctag_if.master    adc,
    input  logic        trig,
    input  logic        force_fs,
    input  logic [1:0]  mode,
    output logic        ctrl_1,
    output logic        led
);
    localparam int CW = $clog2(DETECT_N + 1);
    localparam int BW = $clog2(BURST_CYCLES);
    logic [11:0]   sample;
    logic          sample_valid;
    logic [CW-1:0] det_cnt;
    logic [2:0]    trig_sr;
    logic [BW-1:0] burst_cnt;
    logic [4:0]    half_cnt;
    logic          from_trig;
    logic          above;
    logic          det_req;
    logic          trig_rise;
    logic          half_done;
    state_t        state;
    loctag_adc_rx #(.SAMPLE_DIV(SAMPLE_DIV)) u_adc (
        .clk          (clk),
        .reset        (reset),
        .adc          (adc),
        .sample       (sample),
        .sample_valid (sample_valid)
    );
    assign above     = sample > THRESHOLD;
    assign det_req   = sample_valid && above && det_cnt == CW'(DETECT_N - 1);
    assign trig_rise = trig_sr[1] && !trig_sr[2];
    assign half_done = half_cnt == 5'd0;
    // counter saturates at DETECT_N, so a long carrier requests only once until a low sample re-arms it
    always_ff @(posedge clk) begin
        if (!reset) begin
            det_cnt <= '0;
            trig_sr <= '0;
        end else begin
            trig_sr <= {trig_sr[1:0], trig};
            if (sample_valid)
                det_cnt <= !above ? '0 : det_cnt == CW'(DETECT_N) ? det_cnt : det_cnt + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            burst_cnt <= '0;
            half_cnt  <= '0;
            from_trig <= 1'b0;
            ctrl_1    <= 1'b0;
            led       <= 1'b0;
        end else if (force_fs) begin
            state    <= IDLE;
            led      <= 1'b1;
            ctrl_1   <= half_done ? !ctrl_1 : ctrl_1;
            half_cnt <= half_done ? HALF[mode] - 5'd1 : half_cnt - 5'd1;
        end else begin
            case (state)
                IDLE: begin
                    ctrl_1   <= 1'b0;
                    led      <= 1'b0;
                    half_cnt <= '0;
                    if (det_req || trig_rise) begin
                        state     <= SHIFT;
                        // a simultaneous detect keeps the carrier-drop holdoff
                        from_trig <= !det_req;
                        burst_cnt <= '0;
                        half_cnt  <= HALF[mode] - 5'd1;
                        ctrl_1    <= 1'b1;
                        led       <= 1'b1;
                    end
                end
                SHIFT: begin
                    burst_cnt <= burst_cnt + 1'b1;
                    ctrl_1    <= half_done ? !ctrl_1 : ctrl_1;
                    half_cnt  <= half_done ? HALF[mode] - 5'd1 : half_cnt - 5'd1;
                    if (burst_cnt == BW'(BURST_CYCLES - 1)) begin
                        state  <= HOLDOFF;
                        ctrl_1 <= 1'b0;
                        led    <= 1'b0;
                    end
                end
                HOLDOFF: if (from_trig || (sample_valid && !above)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_loctag_core.sv
// tb_loctag_core: directed checks of ADC framing, envelope detect, trigger bursts and forced shifting
module tb_loctag_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trig = 1'b0;
    logic        force_fs = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        ctrl_1;
    logic        led;
    logic [15:0] model_word = 16'h0000;
    logic [15:0] word = 16'h0000;
    logic [3:0]  bidx = 4'd15;
    int checks = 0;
    int errors = 0;
    loctag_if adc();
    loctag_core dut (
        .clk      (clk),
        .reset    (reset),
        .adc      (adc),
        .trig     (trig),
        .force_fs (force_fs),
        .mode     (mode),
        .ctrl_1   (ctrl_1),
        .led      (led)
    );
    always #5 clk = ~clk;
    initial adc.adc_so = 1'b0;
    // ADC model: word latched on cs fall, one bit per adc_clk falling edge, MSB first
    always @(negedge adc.adc_cs or negedge adc.adc_clk) begin
        if (!adc.adc_clk) begin
            adc.adc_so = word[bidx];
            bidx = bidx - 4'd1;
        end else begin
            word = model_word;
            bidx = 4'd15;
        end
    end
    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic wait_cs(input logic v, input string tag);
        int n = 0;
        while (adc.adc_cs !== v && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check(tag, adc.adc_cs, v);
    endtask
    task automatic frame_end(input string tag);
        wait_cs(1'b1, tag);
        wait_cs(1'b0, tag);
        wait_cs(1'b1, tag);
    endtask
    task automatic ctrl_run(input logic v, output int len);
        len = 0;
        while (ctrl_1 === v && len < 1000) begin
            len++;
            @(negedge clk);
        end
    endtask
    initial begin
        int n, low, rises, hi, lo, len, hits, lat, bad, ledlow, x;
        logic prev, p1, p2;
        repeat (5) @(negedge clk);
        check("rst_cs", adc.adc_cs, 1);
        check("rst_adc_clk", adc.adc_clk, 1);
        check("rst_ctrl_1", ctrl_1, 0);
        check("rst_led", led, 0);
        check("rst_en", adc.lt5534_en, 0);
        reset = 1'b1;
        @(negedge clk);
        check("en_after_release", adc.lt5534_en, 1);
        n = 1;
        while (adc.adc_cs && n < 150) begin
            @(negedge clk);
            n++;
        end
        check("first_cs_fall_le100", n <= 100, 1);
        model_word = 16'h0ABC;
        wait_cs(1'b1, "t2_wait_rise");
        wait_cs(1'b0, "t2_wait_fall");
        low = 0;
        rises = 0;
        prev = adc.adc_clk;
        while (adc.adc_cs === 1'b0 && low < 200) begin
            low++;
            @(negedge clk);
            if (adc.adc_clk && !prev) rises++;
            prev = adc.adc_clk;
        end
        check("cs_low_cycles", low, 66);
        check("adc_clk_rises", rises, 16);
        check("adc_clk_high_at_cs_rise", adc.adc_clk, 1);
        check("sample_abc", dut.sample, 12'hABC);
        check("valid_pulse", dut.sample_valid, 1);
        @(negedge clk);
        check("valid_one_cycle", dut.sample_valid, 0);
        model_word = 16'h0000;
        frame_end("t2_clear");
        model_word = 16'd1200;
        mode = 2'b00;
        n = 0;
        while (!led && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("t3_burst_start", led, 1);
        check("t3_ctrl_first", ctrl_1, 1);
        ctrl_run(1'b1, hi);
        ctrl_run(1'b0, lo);
        check("t3_half_hi", hi, 25);
        check("t3_period", hi + lo, 50);
        len = hi + lo;
        while (led && len < 60000) begin
            len++;
            @(negedge clk);
        end
        check("t3_led_len", len, 50000);
        check("t3_ctrl_after", ctrl_1, 0);
        hits = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (led) hits++;
        end
        check("t4_no_rearm_high", hits, 0);
        model_word = 16'd0;
        frame_end("t4_low");
        model_word = 16'd1200;
        frame_end("t4_f1");
        @(negedge clk);
        check("t4_after_1", led, 0);
        frame_end("t4_f2");
        @(negedge clk);
        check("t4_after_2", led, 0);
        frame_end("t4_f3");
        @(negedge clk);
        check("t4_after_3", led, 1);
        check("t4_ctrl_first", ctrl_1, 1);
        mode = 2'b10;
        force_fs = 1'b1;
        repeat (60) @(negedge clk);
        check("t6_led", led, 1);
        ctrl_run(1'b1, x);
        ctrl_run(1'b0, x);
        ctrl_run(1'b1, hi);
        ctrl_run(1'b0, lo);
        check("t6_half_hi", hi, 5);
        check("t6_period", hi + lo, 10);
        model_word = 16'd0;
        frame_end("t6_low");
        ctrl_run(1'b0, x);
        force_fs = 1'b0;
        @(negedge clk);
        check("t6_ctrl_off", ctrl_1, 0);
        check("t6_led_off", led, 0);
        hits = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (led) hits++;
        end
        check("t6_stays_idle", hits, 0);
        mode = 2'b11;
        trig = 1'b1;
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (led && lat == 0) lat = i;
        end
        trig = 1'b0;
        check("t5_latency_le4", lat >= 1 && lat <= 4, 1);
        ctrl_run(1'b1, x);
        ctrl_run(1'b0, x);
        ctrl_run(1'b1, hi);
        ctrl_run(1'b0, lo);
        check("t5_half_hi", hi, 2);
        check("t5_period", hi + lo, 4);
        p2 = ctrl_1;
        @(negedge clk);
        p1 = ctrl_1;
        bad = 0;
        ledlow = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (i == 20) trig = 1'b1;
            if (i == 24) trig = 1'b0;
            if (ctrl_1 !== ~p2) bad++;
            if (!led) ledlow++;
            p2 = p1;
            p1 = ctrl_1;
        end
        check("t5_pattern_bad", bad, 0);
        check("t5_led_dropped", ledlow, 0);
        force_fs = 1'b1;
        repeat (3) @(negedge clk);
        force_fs = 1'b0;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
